// File: rtl/fmul_f32_seq.sv
// -----------------------------------------------------------------------------
// fmul_f32_seq
//   Sequential IEEE-754 binary32 multiplier, prod = a * b.
//   The 24x24 mantissa product is formed by shift-add over 24 cycles, then a
//   single cycle normalizes, rounds to nearest-even and packs the result.
//   Denormal inputs are flushed to zero and underflowing results are flushed
//   to signed zero; any NaN input or inf*0 gives the quiet NaN 0x7FC00000.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-low reset
//   start  in   1   request, sampled only in IDLE/DONE
//   a      in  32   multiplicand, latched on an accepted start
//   b      in  32   multiplier, latched on an accepted start
//   busy   out  1   high from the edge after acceptance until the result
//   rdy    out  1   level, high while prod holds a valid result
//   prod   out 32   product, stable while rdy is high
// -----------------------------------------------------------------------------
module fmul_f32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             rdy,
    output logic [WIDTH-1:0] prod
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_MUL    = 3'd2;
    localparam logic [2:0] ST_NORM   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]        state_r;
    logic [31:0]       a_r;
    logic [31:0]       b_r;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       ma_r;
    logic [23:0]       mb_r;
    logic [47:0]       acc_r;
    logic [4:0]        cnt_r;

    logic              special_s;
    logic [31:0]       special_val_s;
    logic              sign_s;
    logic              a_zero_s;
    logic              b_zero_s;
    logic              a_inf_s;
    logic              b_inf_s;
    logic              a_nan_s;
    logic              b_nan_s;

    // Normalize the 48-bit product, round to nearest-even and pack.
    // The product of two [1,2) mantissas lies in [1,4), so the leading one is
    // at bit 47 or bit 46; a rounding carry out of the mantissa leaves it zero
    // and bumps the exponent once more.
    function automatic logic [31:0] norm_round(
        input logic [47:0]       acc,
        input logic signed [9:0] exp_in,
        input logic              sgn
    );
        logic [22:0]       mant;
        logic              guard;
        logic              sticky;
        logic              inc;
        logic [23:0]       mant_rnd;
        logic signed [9:0] e;
        logic [31:0]       res;
        if (acc[47]) begin
            mant   = acc[46:24];
            guard  = acc[23];
            sticky = |acc[22:0];
            e      = exp_in + 10'sd1;
        end else begin
            mant   = acc[45:23];
            guard  = acc[22];
            sticky = |acc[21:0];
            e      = exp_in;
        end
        inc      = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, inc};
        if (mant_rnd[23]) begin
            e = e + 10'sd1;
        end else begin
            e = e;
        end
        if (e >= 10'sd255) begin
            res = {sgn, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            res = {sgn, 31'd0};
        end else begin
            res = {sgn, e[7:0], mant_rnd[22:0]};
        end
        return res;
    endfunction

    // Classify the latched operands and pick the special-case result, if any.
    always_comb begin
        sign_s        = a_r[31] ^ b_r[31];
        a_zero_s      = (a_r[30:23] == 8'd0);
        b_zero_s      = (b_r[30:23] == 8'd0);
        a_inf_s       = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
        b_inf_s       = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'd0);
        a_nan_s       = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
        b_nan_s       = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
        special_s     = 1'b0;
        special_val_s = 32'd0;
        // Denormals count as zero, so inf * denormal is also inf * 0.
        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            special_s     = 1'b1;
            special_val_s = QNAN;
        end else if (a_inf_s || b_inf_s) begin
            special_s     = 1'b1;
            special_val_s = {sign_s, 8'hFF, 23'd0};
        end else if (a_zero_s || b_zero_s) begin
            special_s     = 1'b1;
            special_val_s = {sign_s, 31'd0};
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'd0;
        end
    end

    // Control FSM and datapath registers, including the registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            sign_r  <= 1'b0;
            exp_r   <= 10'sd0;
            ma_r    <= 24'd0;
            mb_r    <= 24'd0;
            acc_r   <= 48'd0;
            cnt_r   <= 5'd0;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            prod    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // prod keeps the last result until the next DONE entry.
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        rdy     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_UNPACK;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_UNPACK: begin
                    sign_r <= sign_s;
                    exp_r  <= $signed({2'b00, a_r[30:23]})
                            + $signed({2'b00, b_r[30:23]}) - 10'sd127;
                    ma_r   <= {1'b1, a_r[22:0]};
                    mb_r   <= {1'b1, b_r[22:0]};
                    acc_r  <= 48'd0;
                    cnt_r  <= 5'd0;
                    if (special_s) begin
                        prod    <= special_val_s;
                        rdy     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mb_r[cnt_r]) begin
                        acc_r <= acc_r + ({24'd0, ma_r} << cnt_r);
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (cnt_r == 5'd23) begin
                        state_r <= ST_NORM;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ST_NORM: begin
                    prod    <= norm_round(acc_r, exp_r, sign_r);
                    rdy     <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_DONE;
                end
                default: begin
                    busy    <= 1'b0;
                    rdy     <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_f32_seq.sv
// -----------------------------------------------------------------------------
// tb_fmul_f32_seq
//   Self-checking bench for fmul_f32_seq. Expected products come from an
//   integer reference: full 64-bit mantissa product, then round-to-nearest-even
//   by remainder comparison, with the block's flush-to-zero rules.
// -----------------------------------------------------------------------------
module tb_fmul_f32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        rdy;
    logic [31:0] prod;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_prod;

    fmul_f32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .busy  (busy),
        .rdy   (rdy),
        .prod  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, got, want);
        end
    endtask

    function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'd0) || (y[30:23] == 8'd0) ||
               (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, e, sh;
        bit s, zx, zy, ix, iy, nx, ny;
        longint unsigned mx, my, p, q, rem, half;
        logic [31:0] r;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 23'd0);
        iy = (ey == 255) && (y[22:0] == 23'd0);
        nx = (ex == 255) && (x[22:0] != 23'd0);
        ny = (ey == 255) && (y[22:0] != 23'd0);
        if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC0_0000;
        if (ix || iy) return {s, 8'hFF, 23'd0};
        if (zx || zy) return {s, 31'd0};
        mx = 64'h80_0000 + 64'(x[22:0]);
        my = 64'h80_0000 + 64'(y[22:0]);
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q >= (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        r = {s, 8'(e), q[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rnd_float();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6)       r[30:23] = 8'($urandom_range(100, 154));
        else if (k == 6) r[30:23] = 8'd0;
        else if (k == 7) r[30:23] = 8'hFF;
        else if (k == 8) r[30:23] = 8'($urandom_range(190, 254));
        else             r[30:23] = r[30:23];
        if (k == 7 && $urandom_range(0, 1) == 0) r[22:0] = 23'd0;
        return r;
    endfunction

    // Compare process: whenever a result is presented it must match the model
    // and busy must be low.
    always @(negedge clk) begin
        if (rst && rdy) begin
            chk("prod_while_rdy", prod, exp_prod);
            chk("busy_while_rdy", {31'd0, busy}, 32'd0);
        end
    end

    // Issue one operation (called at posedge+#1) and wait for its result.
    // pulse_at >= 0 pulses a competing start that many edges into the op.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] want, input int pulse_at);
        int  lat;
        bit  seen;
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exp_prod = ref_mul(x, y);
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_rdy", {31'd0, rdy}, 32'd0);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (lat == pulse_at) begin
                a_in  = 32'h7F80_0000;
                b_in  = 32'h0000_0000;
                start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (rdy) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: rdy not seen after %0d edges, expected within 40", lat);
        end else begin
            chk("latency", 32'(lat), is_special(x, y) ? 32'd1 : 32'd26);
            chk("result", prod, want);
        end
    endtask

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
    } vec_t;

    vec_t dir_tab[12] = '{
        '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000},
        '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000},
        '{32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000},
        '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002},
        '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE},
        '{32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002},
        '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000},
        '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000},
        '{32'h0040_0000, 32'h4000_0000, 32'h0000_0000},
        '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000},
        '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000},
        '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000}
    };

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        n_vec    = 0;
        n_err    = 0;
        exp_prod = 32'd0;
        rst      = 1'b0;
        start    = 1'b0;
        a_in     = 32'd0;
        b_in     = 32'd0;

        // Pin the reference model with hand-computed products.
        for (int i = 0; i < 12; i++)
            chk("model_pin", ref_mul(dir_tab[i].x, dir_tab[i].y), dir_tab[i].r);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", {31'd0, rdy}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_prod", prod, 32'd0);

        // Reset coinciding with start: reset wins.
        a_in  = 32'h4000_0000;
        b_in  = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        chk("rst_vs_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("rst_vs_start_idle", {31'd0, busy}, 32'd0);

        // Directed vectors, issued back-to-back in the first DONE cycle.
        for (int i = 0; i < 12; i++)
            run_op(dir_tab[i].x, dir_tab[i].y, dir_tab[i].r, -1);

        // Competing start during MUL is ignored.
        run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5);

        // Reset at E10 of an operation, then a fresh operation.
        a_in  = 32'h3FC0_0000;
        b_in  = 32'h3FC0_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_rdy", {31'd0, rdy}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_prod", prod, 32'd0);
        run_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, -1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            x = rnd_float();
            y = rnd_float();
            run_op(x, y, ref_mul(x, y), -1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
